// File: rtl/k12a_ram_ctrl.sv
// k12a_ram_ctrl: clocked valid/ready front-end for a 62256-style asynchronous SRAM.
// Sequences CE/OE/WE with address setup, write-data hold and a read bus turnaround.
module k12a_ram_ctrl #(
  parameter int unsigned RD_WAIT_CYCLES  = 2,
  parameter int unsigned WR_PULSE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_write,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic [14:0] ram_addr,
  inout  wire  [7:0]  ram_data,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n
);

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;

  localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT_CYCLES - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    RD_TURN   = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          accept;
  logic          capture;
  logic [DW-1:0] wdata_q;
  logic          bus_oe;
  logic          ce_nx;
  logic          oe_nx;
  logic          we_nx;
  logic          bus_oe_nx;

  // The bus is only ever driven from registered enable and data.
  assign ram_data = bus_oe ? wdata_q : {DW{1'bz}};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, counter and datapath enables
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    capture  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (req_write) begin
            state_nx = WR_SETUP;
          end else begin
            state_nx = RD_ACCESS;
            cnt_nx   = RD_LOAD;
          end
        end
      end
      RD_ACCESS: begin
        if (cnt == '0) begin
          capture  = 1'b1;
          state_nx = RD_TURN;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      RD_TURN:  state_nx = IDLE;
      WR_SETUP: begin
        state_nx = WR_PULSE;
        cnt_nx   = WR_LOAD;
      end
      WR_PULSE: begin
        if (cnt == '0) begin
          state_nx = WR_HOLD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      WR_HOLD:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Strobe values decoded from the next state so the registered pins track the state
  always_comb begin
    ready     = (state == IDLE);
    ce_nx     = 1'b1;
    oe_nx     = 1'b1;
    we_nx     = 1'b1;
    bus_oe_nx = 1'b0;
    case (state_nx)
      RD_ACCESS: begin
        ce_nx = 1'b0;
        oe_nx = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_nx     = 1'b0;
        bus_oe_nx = 1'b1;
      end
      WR_PULSE: begin
        ce_nx     = 1'b0;
        we_nx     = 1'b0;
        bus_oe_nx = 1'b1;
      end
      default: begin
        ce_nx = 1'b1;
      end
    endcase
  end

  // Registered outputs, counter and latched request fields
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      ram_addr    <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      ram_ce_n    <= 1'b1;
      ram_oe_n    <= 1'b1;
      ram_we_n    <= 1'b1;
      bus_oe      <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      if (accept) begin
        ram_addr <= AW'(req_addr);
        wdata_q  <= DW'(req_wdata);
      end
      if (capture) begin
        rdata <= ram_data;
      end
      rdata_valid <= capture;
      ram_ce_n    <= ce_nx;
      ram_oe_n    <= oe_nx;
      ram_we_n    <= we_nx;
      bus_oe      <= bus_oe_nx;
    end
  end

endmodule

// File: tb/tb_k12a_ram_ctrl.sv
// tb_k12a_ram_ctrl: three controller instances (2/2, 1/1, 15/15 cycle settings),
// each with its own behavioural SRAM, exercised by directed scenario tasks.
module tb_k12a_ram_ctrl;

  localparam int unsigned NCFG = 3;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_a       [NCFG];
  logic        req_write_a [NCFG];
  logic [14:0] req_addr_a  [NCFG];
  logic [7:0]  req_wdata_a [NCFG];
  logic        ready_a       [NCFG];
  logic [7:0]  rdata_a       [NCFG];
  logic        rdata_valid_a [NCFG];
  logic [14:0] ram_addr_a    [NCFG];
  logic        ce_n_a [NCFG];
  logic        oe_n_a [NCFG];
  logic        we_n_a [NCFG];

  int cyc      = 0;
  int checks   = 0;
  int passes   = 0;
  int last_acc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned PAR = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    wire  [7:0]  bus;
    logic [7:0]  mem [32768];
    int          inv_err     = 0;
    logic        prev_ce_low = 1'b0;
    logic [14:0] prev_addr   = '0;

    k12a_ram_ctrl #(.RD_WAIT_CYCLES(PAR), .WR_PULSE_CYCLES(PAR)) u_dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req_a[g]),
      .req_write  (req_write_a[g]),
      .req_addr   (req_addr_a[g]),
      .req_wdata  (req_wdata_a[g]),
      .ready      (ready_a[g]),
      .rdata      (rdata_a[g]),
      .rdata_valid(rdata_valid_a[g]),
      .ram_addr   (ram_addr_a[g]),
      .ram_data   (bus),
      .ram_ce_n   (ce_n_a[g]),
      .ram_oe_n   (oe_n_a[g]),
      .ram_we_n   (we_n_a[g])
    );

    // SRAM model: drives the bus on CE&OE, stores the bus while CE&WE are low
    assign bus = (!ce_n_a[g] && !oe_n_a[g] && we_n_a[g]) ? mem[ram_addr_a[g]] : 8'bz;
    always @(posedge clock) if (!ce_n_a[g] && !we_n_a[g]) mem[ram_addr_a[g]] <= bus;

    always @(negedge clock) begin
      if (!oe_n_a[g] && !we_n_a[g]) inv_err <= inv_err + 1;
      if (!oe_n_a[g] && u_dut.bus_oe) inv_err <= inv_err + 1;
      if (prev_ce_low && !ce_n_a[g] && (ram_addr_a[g] != prev_addr)) inv_err <= inv_err + 1;
      prev_ce_low <= !ce_n_a[g];
      prev_addr   <= ram_addr_a[g];
    end
  end

  function automatic int par_of(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Expects req already raised; returns on the negedge just after the accept edge.
  task automatic wait_accept(input int k, input string name);
    int n = 0;
    while (!ready_a[k] && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (!ready_a[k]) begin
      checks++;
      $display("FAIL %s accept: ready still low after %0d cycles", name, n);
    end
    @(negedge clock);
    last_acc = cyc;
  endtask

  task automatic do_write(input int k, input logic [14:0] a, input logic [7:0] d,
                          input bit keep, input string name);
    int   wp       = par_of(k);
    int   we_cnt   = 0;
    int   first_we = -1;
    int   idle_at  = -1;
    logic ce0      = 1'b1;
    req_write_a[k] = 1'b1;
    req_addr_a[k]  = a;
    req_wdata_a[k] = d;
    req_a[k]       = 1'b1;
    wait_accept(k, name);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) ce0 = ce_n_a[k];
      if (!we_n_a[k]) begin
        we_cnt++;
        if (first_we < 0) first_we = i;
      end
      if (ready_a[k]) begin
        idle_at = i;
        break;
      end
      @(negedge clock);
    end
    if (!keep) req_a[k] = 1'b0;
    checks++; if (ce0 !== 1'b0) $display("FAIL %s ce_after_E0: got %b want 0", name, ce0); else passes++;
    checks++; if (first_we != 1) $display("FAIL %s we_first: got E%0d want E1", name, first_we); else passes++;
    checks++; if (we_cnt != wp) $display("FAIL %s we_low_cycles: got %0d want %0d", name, we_cnt, wp); else passes++;
    checks++; if (idle_at != wp + 2) $display("FAIL %s idle_at: got E%0d want E%0d", name, idle_at, wp + 2); else passes++;
  endtask

  task automatic do_read(input int k, input logic [14:0] a, input logic [7:0] d,
                         input bit keep, input string name);
    int         rw       = par_of(k);
    int         nvalid   = 0;
    int         valid_at = -1;
    int         idle_at  = -1;
    logic [7:0] got      = 8'h00;
    req_write_a[k] = 1'b0;
    req_addr_a[k]  = a;
    req_a[k]       = 1'b1;
    wait_accept(k, name);
    for (int i = 0; i < 40; i++) begin
      if (rdata_valid_a[k]) begin
        nvalid++;
        if (valid_at < 0) begin
          valid_at = i;
          got      = rdata_a[k];
        end
      end
      if (ready_a[k]) begin
        idle_at = i;
        break;
      end
      @(negedge clock);
    end
    if (!keep) req_a[k] = 1'b0;
    checks++; if (got !== d) $display("FAIL %s rdata: got %h want %h", name, got, d); else passes++;
    checks++; if (valid_at != rw) $display("FAIL %s valid_at: got E%0d want E%0d", name, valid_at, rw); else passes++;
    checks++; if (nvalid != 1) $display("FAIL %s valid_pulses: got %0d want 1", name, nvalid); else passes++;
    checks++; if (idle_at != rw + 1) $display("FAIL %s idle_at: got E%0d want E%0d", name, idle_at, rw + 1); else passes++;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++; if ({ce_n_a[0], oe_n_a[0], we_n_a[0]} !== 3'b111) $display("FAIL reset strobes: got %b want 111", {ce_n_a[0], oe_n_a[0], we_n_a[0]}); else passes++;
    checks++; if (g_cfg[0].u_dut.bus_oe !== 1'b0) $display("FAIL reset bus_drive: got %b want 0", g_cfg[0].u_dut.bus_oe); else passes++;
    checks++; if (rdata_a[0] !== 8'h00) $display("FAIL reset rdata: got %h want 00", rdata_a[0]); else passes++;
    checks++; if (rdata_valid_a[0] !== 1'b0) $display("FAIL reset rdata_valid: got %b want 0", rdata_valid_a[0]); else passes++;
    checks++; if (ram_addr_a[0] !== 15'h0000) $display("FAIL reset ram_addr: got %h want 0000", ram_addr_a[0]); else passes++;
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (ready_a[0] !== 1'b1) $display("FAIL reset ready: got %b want 1", ready_a[0]); else passes++;
  endtask

  task automatic test_write_read();
    do_write(0, 15'h1234, 8'h5A, 1'b0, "wr_default");
    @(negedge clock);
    do_read(0, 15'h1234, 8'h5A, 1'b0, "rd_default");
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, a3;
    @(negedge clock);
    do_write(0, 15'h0000, 8'h11, 1'b1, "b2b_wr0"); a0 = last_acc;
    do_write(0, 15'h7FFF, 8'hEE, 1'b1, "b2b_wr1"); a1 = last_acc;
    do_read(0, 15'h0000, 8'h11, 1'b1, "b2b_rd0");  a2 = last_acc;
    do_read(0, 15'h7FFF, 8'hEE, 1'b0, "b2b_rd1");  a3 = last_acc;
    checks++; if (a1 - a0 != 5) $display("FAIL b2b write_period: got %0d want 5", a1 - a0); else passes++;
    checks++; if (a2 - a1 != 5) $display("FAIL b2b write_to_read: got %0d want 5", a2 - a1); else passes++;
    checks++; if (a3 - a2 != 4) $display("FAIL b2b read_period: got %0d want 4", a3 - a2); else passes++;
  endtask

  task automatic test_param_min();
    int a0, a1, a2, a3;
    @(negedge clock);
    do_write(1, 15'h0010, 8'hA5, 1'b1, "min_wr0"); a0 = last_acc;
    do_write(1, 15'h0011, 8'h3C, 1'b1, "min_wr1"); a1 = last_acc;
    do_read(1, 15'h0010, 8'hA5, 1'b1, "min_rd0");  a2 = last_acc;
    do_read(1, 15'h0011, 8'h3C, 1'b0, "min_rd1");  a3 = last_acc;
    checks++; if (a1 - a0 != 4) $display("FAIL min write_period: got %0d want 4", a1 - a0); else passes++;
    checks++; if (a3 - a2 != 3) $display("FAIL min read_period: got %0d want 3", a3 - a2); else passes++;
  endtask

  task automatic test_param_max();
    @(negedge clock);
    do_write(2, 15'h4321, 8'h96, 1'b0, "max_wr");
    @(negedge clock);
    do_read(2, 15'h4321, 8'h96, 1'b0, "max_rd");
  endtask

  task automatic test_busy();
    int nvalid = 0;
    @(negedge clock);
    do_write(0, 15'h0100, 8'hC3, 1'b0, "busy_prewr");
    req_write_a[0] = 1'b1;
    req_addr_a[0]  = 15'h0200;
    req_wdata_a[0] = 8'h77;
    req_a[0]       = 1'b1;
    wait_accept(0, "busy_wr");
    req_a[0] = 1'b0;
    @(negedge clock);
    checks++; if (we_n_a[0] !== 1'b0) $display("FAIL busy in_pulse: we_n got %b want 0", we_n_a[0]); else passes++;
    req_write_a[0] = 1'b0;
    req_addr_a[0]  = 15'h0100;
    req_a[0]       = 1'b1;
    @(negedge clock);
    req_a[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rdata_valid_a[0]) nvalid++;
      @(negedge clock);
    end
    checks++; if (nvalid != 0) $display("FAIL busy extra_valid: got %0d want 0", nvalid); else passes++;
    checks++; if (ram_addr_a[0] !== 15'h0200) $display("FAIL busy ram_addr: got %h want 0200", ram_addr_a[0]); else passes++;
    do_read(0, 15'h0200, 8'h77, 1'b0, "busy_rd_wr");
    @(negedge clock);
    do_read(0, 15'h0100, 8'hC3, 1'b0, "busy_rd_unchanged");
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    @(negedge clock);
    req_write_a[0] = 1'b1;
    req_addr_a[0]  = 15'h0300;
    req_wdata_a[0] = 8'h55;
    req_a[0]       = 1'b1;
    wait_accept(0, "midrst_wr");
    req_a[0] = 1'b0;
    @(negedge clock);
    checks++; if (we_n_a[0] !== 1'b0) $display("FAIL midrst in_pulse: we_n got %b want 0", we_n_a[0]); else passes++;
    reset_n = 1'b0;
    #1;
    checks++; if ({ce_n_a[0], oe_n_a[0], we_n_a[0]} !== 3'b111) $display("FAIL midrst strobes: got %b want 111", {ce_n_a[0], oe_n_a[0], we_n_a[0]}); else passes++;
    checks++; if (g_cfg[0].u_dut.bus_oe !== 1'b0) $display("FAIL midrst bus_drive: got %b want 0", g_cfg[0].u_dut.bus_oe); else passes++;
    checks++; if (rdata_a[0] !== 8'h00) $display("FAIL midrst rdata: got %h want 00", rdata_a[0]); else passes++;
    checks++; if (ram_addr_a[0] !== 15'h0000) $display("FAIL midrst ram_addr: got %h want 0000", ram_addr_a[0]); else passes++;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (rdata_valid_a[0]) nvalid++;
    end
    checks++; if (ready_a[0] !== 1'b1) $display("FAIL midrst ready: got %b want 1", ready_a[0]); else passes++;
    checks++; if (nvalid != 0) $display("FAIL midrst valid: got %0d want 0", nvalid); else passes++;
    do_read(0, 15'h1234, 8'h5A, 1'b0, "midrst_rd");
  endtask

  task automatic test_invariants();
    int errs = g_cfg[0].inv_err + g_cfg[1].inv_err + g_cfg[2].inv_err;
    checks++; if (errs != 0) $display("FAIL invariants: got %0d violations want 0", errs); else passes++;
  endtask

  initial begin
    for (int k = 0; k < NCFG; k++) begin
      req_a[k]       = 1'b0;
      req_write_a[k] = 1'b0;
      req_addr_a[k]  = '0;
      req_wdata_a[k] = '0;
    end
    test_reset();
    test_write_read();
    test_back_to_back();
    test_param_min();
    test_param_max();
    test_busy();
    test_reset_mid();
    @(negedge clock);
    test_invariants();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
    $fatal(1);
  end

endmodule
